// File: rtl/mem_stage.sv
// Memory stage: captures one execute-stage op, performs at most one data-memory
// access (request/grant then response), and presents a one-cycle writeback beat.
module mem_stage (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_data_2,
  input  logic        i_mem_rw,
  input  logic [2:0]  i_load_store_mode,
  input  logic [1:0]  i_wb_sel,
  input  logic [31:0] i_pc_inc,
  input  logic        i_reg_wr_en,
  output logic        o_stall,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_alu_result,
  output logic [31:0] o_load_data,
  output logic [31:0] o_pc_inc,
  output logic [1:0]  o_wb_sel,
  output logic        o_reg_wr_en,
  output logic        o_misaligned
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  // Unlisted mode codes fall back to a full word access.
  function automatic size_e decodeSize(input logic [2:0] mode);
    case (mode)
      3'b000, 3'b100: decodeSize = SZ_B;
      3'b001, 3'b101: decodeSize = SZ_H;
      default:        decodeSize = SZ_W;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] loadData_q, loadData_d;

  logic [31:0] inst_q, aluResult_q, data2_q, pcInc_q;
  logic        memRw_q, unsigned_q, regWrEn_q, misaligned_q;
  logic [1:0]  wbSel_q;
  size_e       size_q;

  logic        captureEn, inIsMem, inMisaligned;
  size_e       inSize;
  logic [3:0]  storeLanes;
  logic [31:0] storeData, rdShifted, loadExt;

  assign captureEn = (state_q == IDLE) && i_valid;
  assign inIsMem   = i_mem_rw || (i_wb_sel == 2'b00);
  assign inSize    = decodeSize(i_load_store_mode);
  assign inMisaligned = inIsMem &&
                        (((inSize == SZ_H) && i_alu_result[0]) ||
                         ((inSize == SZ_W) && (i_alu_result[1:0] != 2'b00)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inst_q       <= '0;
      aluResult_q  <= '0;
      data2_q      <= '0;
      pcInc_q      <= '0;
      memRw_q      <= 1'b0;
      unsigned_q   <= 1'b0;
      regWrEn_q    <= 1'b0;
      misaligned_q <= 1'b0;
      wbSel_q      <= '0;
      size_q       <= SZ_B;
    end else if (captureEn) begin
      inst_q       <= i_inst;
      aluResult_q  <= i_alu_result;
      data2_q      <= i_data_2;
      pcInc_q      <= i_pc_inc;
      memRw_q      <= i_mem_rw;
      unsigned_q   <= (i_load_store_mode == 3'b100) || (i_load_store_mode == 3'b101);
      regWrEn_q    <= i_reg_wr_en;
      misaligned_q <= inMisaligned;
      wbSel_q      <= i_wb_sel;
      size_q       <= inSize;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      loadData_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      loadData_q <= loadData_d;
    end
  end

  // Shifting the addressed lane down to bit 0 makes extraction offset-free.
  always_comb begin
    rdShifted = i_dmem_rdata >> {aluResult_q[1:0], 3'b000};
    case (size_q)
      SZ_B:    loadExt = unsigned_q ? {24'b0, rdShifted[7:0]}
                                    : {{24{rdShifted[7]}}, rdShifted[7:0]};
      SZ_H:    loadExt = unsigned_q ? {16'b0, rdShifted[15:0]}
                                    : {{16{rdShifted[15]}}, rdShifted[15:0]};
      default: loadExt = i_dmem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = 1'b0;
    loadData_d = loadData_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (!inIsMem || inMisaligned) valid_d = 1'b1;
          else                          state_d = REQ;
        end
      end
      REQ: begin
        if (i_dmem_gnt) begin
          if (memRw_q) begin
            state_d = IDLE;
            valid_d = 1'b1;
          end else begin
            state_d = RSP;
          end
        end
      end
      RSP: begin
        if (i_dmem_rvalid) begin
          state_d    = IDLE;
          valid_d    = 1'b1;
          loadData_d = loadExt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (size_q)
      SZ_B: begin
        storeLanes = 4'b0001 << aluResult_q[1:0];
        storeData  = {4{data2_q[7:0]}};
      end
      SZ_H: begin
        storeLanes = 4'b0011 << aluResult_q[1:0];
        storeData  = {2{data2_q[15:0]}};
      end
      default: begin
        storeLanes = 4'b1111;
        storeData  = data2_q;
      end
    endcase
  end

  always_comb begin
    o_stall      = (state_q != IDLE);
    o_dmem_req   = (state_q == REQ);
    o_dmem_we    = o_dmem_req && memRw_q;
    o_dmem_be    = o_dmem_req ? storeLanes : 4'b0000;
    o_dmem_addr  = {aluResult_q[31:2], 2'b00};
    o_dmem_wdata = storeData;
    o_valid      = valid_q;
    o_inst       = inst_q;
    o_alu_result = aluResult_q;
    o_load_data  = loadData_q;
    o_pc_inc     = pcInc_q;
    o_wb_sel     = wbSel_q;
    o_reg_wr_en  = regWrEn_q && !misaligned_q;
    o_misaligned = valid_q && misaligned_q;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a memory responder model, a request checker
// and a writeback monitor run alongside directed and random stimulus.
module tb_mem_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid;
  logic [31:0] i_inst, i_alu_result, i_data_2, i_pc_inc;
  logic        i_mem_rw, i_reg_wr_en;
  logic [2:0]  i_load_store_mode;
  logic [1:0]  i_wb_sel;
  logic        o_stall, o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_gnt, i_dmem_rvalid;
  logic [31:0] i_dmem_rdata;
  logic        o_valid, o_reg_wr_en, o_misaligned;
  logic [31:0] o_inst, o_alu_result, o_load_data, o_pc_inc;
  logic [1:0]  o_wb_sel;

  mem_stage dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_inst(i_inst),
    .i_alu_result(i_alu_result), .i_data_2(i_data_2), .i_mem_rw(i_mem_rw),
    .i_load_store_mode(i_load_store_mode), .i_wb_sel(i_wb_sel), .i_pc_inc(i_pc_inc),
    .i_reg_wr_en(i_reg_wr_en), .o_stall(o_stall), .o_dmem_req(o_dmem_req),
    .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
    .o_dmem_be(o_dmem_be), .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvalid(i_dmem_rvalid),
    .i_dmem_rdata(i_dmem_rdata), .o_valid(o_valid), .o_inst(o_inst),
    .o_alu_result(o_alu_result), .o_load_data(o_load_data), .o_pc_inc(o_pc_inc),
    .o_wb_sel(o_wb_sel), .o_reg_wr_en(o_reg_wr_en), .o_misaligned(o_misaligned)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] load;
    logic [1:0]  wbSel;
    logic        regWrEn;
    logic        mis;
    logic        isLoad;
  } expTxn_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } expReq_t;

  expTxn_t     expQ[$];
  expReq_t     reqQ[$];
  logic [31:0] memOv [logic [31:0]];
  int          checks = 0;
  int          failures = 0;
  bit          autoMode = 1'b1;
  int          forcedGntWait = -1;
  int          lastReqLen = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Read-only memory: explicit overrides, otherwise a hash of the word address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (memOv.exists(a)) return memOv[a];
    return (a * 32'h9E3779B1) ^ 32'hC3A55A3C;
  endfunction

  function automatic int sizeBytes(input logic [2:0] m);
    case (m)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  // Waits for the stage to accept, predicts the outcome, and drives one op.
  task automatic applyStimulus(input logic [31:0] inst, input logic [31:0] alu,
                               input logic [31:0] data2, input logic [31:0] pc,
                               input logic rw, input logic [2:0] mode,
                               input logic [1:0] wbSel, input logic wrEn);
    int waitCycles = 0;
    int sz, off;
    logic isLoad, isMem;
    logic [31:0] w, v;
    expTxn_t e;
    expReq_t r;
    while (o_stall && waitCycles < 300) begin
      @(posedge i_clk); #1;
      waitCycles++;
    end
    if (o_stall) begin
      checks++;
      failures++;
      $display("[TB] FAIL stallTimeout actual=1 expected=0");
      return;
    end
    sz = sizeBytes(mode);
    off = int'(alu % 4);
    isLoad = !rw && (wbSel == 2'b00);
    isMem = rw || isLoad;
    e.inst = inst;
    e.alu = alu;
    e.pc = pc;
    e.wbSel = wbSel;
    e.mis = isMem && ((alu % sz) != 0);
    e.regWrEn = wrEn && !e.mis;
    e.isLoad = isLoad && !e.mis;
    v = 32'd0;
    if (e.isLoad) begin
      w = memWord(alu - off);
      v = w >> (8 * off);
      if (sz == 1) begin
        v = v & 32'hFF;
        if (mode == 3'd0 && v >= 128) v = v | 32'hFFFFFF00;
      end else if (sz == 2) begin
        v = v & 32'hFFFF;
        if (mode == 3'd1 && v >= 32768) v = v | 32'hFFFF0000;
      end
    end
    e.load = v;
    if (isMem && !e.mis) begin
      r.addr = alu - off;
      r.we = rw;
      r.be = 4'(((1 << sz) - 1) << off);
      if (sz == 1)      r.wdata = (data2 & 32'hFF) * 32'h01010101;
      else if (sz == 2) r.wdata = (data2 & 32'hFFFF) * 32'h00010001;
      else              r.wdata = data2;
      reqQ.push_back(r);
    end
    expQ.push_back(e);
    i_inst = inst; i_alu_result = alu; i_data_2 = data2; i_pc_inc = pc;
    i_mem_rw = rw; i_load_store_mode = mode; i_wb_sel = wbSel; i_reg_wr_en = wrEn;
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((expQ.size() != 0 || o_stall) && n < 400) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (expQ.size() != 0 || o_stall) begin
      checks++;
      failures++;
      $display("[TB] FAIL idleTimeout actual=%0d pending expected=0", expQ.size());
    end
  endtask

  // Writeback monitor: every o_valid beat must match the oldest prediction.
  initial begin
    expTxn_t e;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_valid) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpectedValid actual=1 expected=0");
        end else begin
          e = expQ.pop_front();
          checkOutput("wbInst", o_inst, e.inst);
          checkOutput("wbAlu", o_alu_result, e.alu);
          checkOutput("wbPc", o_pc_inc, e.pc);
          checkOutput("wbSel", 32'(o_wb_sel), 32'(e.wbSel));
          checkOutput("wbRegWrEn", 32'(o_reg_wr_en), 32'(e.regWrEn));
          checkOutput("wbMisaligned", 32'(o_misaligned), 32'(e.mis));
          if (e.isLoad) checkOutput("wbLoadData", o_load_data, e.load);
        end
      end
    end
  end

  // Request checker: first cycle against prediction, later cycles for stability.
  initial begin
    bit holding = 1'b0;
    int len = 0;
    expReq_t cur;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        holding = 1'b0;
        len = 0;
      end else if (o_dmem_req) begin
        if (!holding) begin
          holding = 1'b1;
          len = 0;
          if (reqQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpectedReq actual=0x%08h expected=none", o_dmem_addr);
            cur.addr = o_dmem_addr; cur.we = o_dmem_we; cur.be = o_dmem_be; cur.wdata = o_dmem_wdata;
          end else begin
            cur = reqQ.pop_front();
            checkOutput("reqAddr", o_dmem_addr, cur.addr);
            checkOutput("reqWe", 32'(o_dmem_we), 32'(cur.we));
            checkOutput("reqBe", 32'(o_dmem_be), 32'(cur.be));
            if (cur.we) checkOutput("reqWdata", o_dmem_wdata, cur.wdata);
          end
        end else begin
          checkOutput("reqHoldAddr", o_dmem_addr, cur.addr);
          checkOutput("reqHoldBe", 32'(o_dmem_be), 32'(cur.be));
          if (cur.we) checkOutput("reqHoldWdata", o_dmem_wdata, cur.wdata);
        end
        len++;
        if (i_dmem_gnt) begin
          holding = 1'b0;
          lastReqLen = len;
        end
      end else begin
        holding = 1'b0;
      end
    end
  end

  // Memory responder with random grant/response waits and stray rvalid pulses.
  initial begin
    bit inReq = 1'b0;
    bit pend = 1'b0;
    int gntWait = 0;
    int rspWait = 0;
    logic [31:0] rspAddr = 32'd0;
    i_dmem_gnt = 1'b0;
    i_dmem_rvalid = 1'b0;
    i_dmem_rdata = 32'd0;
    forever begin
      @(posedge i_clk); #1;
      if (autoMode) begin
        i_dmem_gnt = 1'b0;
        i_dmem_rvalid = 1'b0;
        if (!i_rst_n) begin
          inReq = 1'b0;
          pend = 1'b0;
        end else begin
          if (pend) begin
            if (rspWait == 0) begin
              i_dmem_rvalid = 1'b1;
              i_dmem_rdata = memWord(rspAddr);
              pend = 1'b0;
            end else rspWait--;
          end else if ($urandom_range(0, 7) == 0) begin
            i_dmem_rvalid = 1'b1;
            i_dmem_rdata = $urandom;
          end
          if (o_dmem_req) begin
            if (!inReq) begin
              inReq = 1'b1;
              gntWait = (forcedGntWait >= 0) ? forcedGntWait : int'($urandom_range(0, 3));
            end
            if (gntWait == 0) begin
              i_dmem_gnt = 1'b1;
              inReq = 1'b0;
              if (!o_dmem_we) begin
                pend = 1'b1;
                rspAddr = o_dmem_addr;
                rspWait = int'($urandom_range(0, 3));
              end
            end else gntWait--;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  wb;
    logic        rw;
    logic [31:0] alu;
    int          kind;
    i_valid = 1'b0; i_inst = '0; i_alu_result = '0; i_data_2 = '0; i_pc_inc = '0;
    i_mem_rw = 1'b0; i_load_store_mode = '0; i_wb_sel = '0; i_reg_wr_en = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("rstValid", 32'(o_valid), 0);
    checkOutput("rstStall", 32'(o_stall), 0);
    checkOutput("rstReq", 32'(o_dmem_req), 0);
    checkOutput("rstWe", 32'(o_dmem_we), 0);
    checkOutput("rstBe", 32'(o_dmem_be), 0);
    checkOutput("rstMis", 32'(o_misaligned), 0);
    checkOutput("rstRegWrEn", 32'(o_reg_wr_en), 0);
    checkOutput("rstAlu", o_alu_result, 0);
    checkOutput("rstLoad", o_load_data, 0);
    checkOutput("rstInst", o_inst, 0);
    checkOutput("rstAddr", o_dmem_addr, 0);
    checkOutput("rstWbSel", 32'(o_wb_sel), 0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Non-memory op completes one cycle after capture without stalling.
    applyStimulus(32'h00B50533, 32'h00001234, 32'h0, 32'h00000104, 1'b0, 3'b000, 2'b01, 1'b1);
    checkOutput("aluLatency", 32'(o_valid), 1);
    checkOutput("aluNoStall", 32'(o_stall), 0);
    checkOutput("aluResult", o_alu_result, 32'h00001234);

    // Store byte with a two-cycle grant delay.
    forcedGntWait = 2;
    applyStimulus(32'h00B501A3, 32'h00001003, 32'h000000AB, 32'h00000108, 1'b1, 3'b000, 2'b00, 1'b0);
    checkOutput("sbStall", 32'(o_stall), 1);
    checkOutput("sbBe", 32'(o_dmem_be), 32'h8);
    checkOutput("sbWdata", o_dmem_wdata, 32'hABABABAB);
    checkOutput("sbAddr", o_dmem_addr, 32'h00001000);
    waitIdle();
    forcedGntWait = -1;
    checkOutput("sbReqLen", 32'(lastReqLen), 3);

    // Sign- and zero-extending loads.
    memOv[32'h00002000] = 32'h00008000;
    applyStimulus(32'h00150503, 32'h00002001, 32'h0, 32'h0000010C, 1'b0, 3'b000, 2'b00, 1'b1);
    waitIdle();
    checkOutput("lbData", o_load_data, 32'hFFFFFF80);
    memOv[32'h00002000] = 32'hBEEF0000;
    applyStimulus(32'h00255503, 32'h00002002, 32'h0, 32'h00000110, 1'b0, 3'b101, 2'b00, 1'b1);
    waitIdle();
    checkOutput("lhuData", o_load_data, 32'h0000BEEF);

    // Misaligned word load never reaches memory.
    applyStimulus(32'h00252503, 32'h00003002, 32'h0, 32'h00000114, 1'b0, 3'b010, 2'b00, 1'b1);
    checkOutput("misValid", 32'(o_valid), 1);
    checkOutput("misFlag", 32'(o_misaligned), 1);
    checkOutput("misRegWrEn", 32'(o_reg_wr_en), 0);
    checkOutput("misNoReq", 32'(o_dmem_req), 0);
    waitIdle();

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin
        @(posedge i_clk); #1;
      end
      kind = int'($urandom_range(0, 2));
      alu = $urandom;
      if (kind == 0) begin
        rw = 1'b0; wb = 2'($urandom_range(1, 3)); alu = alu & 32'hFFFFFFFC;
      end else if (kind == 1) begin
        rw = 1'b0; wb = 2'b00;
      end else begin
        rw = 1'b1; wb = 2'($urandom_range(0, 3));
      end
      applyStimulus($urandom, alu, $urandom, $urandom, rw, 3'($urandom_range(0, 7)), wb,
                    1'($urandom_range(0, 1)));
    end
    waitIdle();
    checkOutput("reqDrained", 32'(reqQ.size()), 0);

    // Reset while waiting for a load response; the late rvalid must be ignored.
    @(negedge i_clk);
    autoMode = 1'b0;
    @(posedge i_clk); #1;
    i_dmem_gnt = 1'b0;
    i_dmem_rvalid = 1'b0;
    applyStimulus(32'h00052503, 32'h00004000, 32'h0, 32'h00000200, 1'b0, 3'b010, 2'b00, 1'b1);
    checkOutput("rspReq", 32'(o_dmem_req), 1);
    i_dmem_gnt = 1'b1;
    @(posedge i_clk); #1;
    i_dmem_gnt = 1'b0;
    checkOutput("rspStall", 32'(o_stall), 1);
    checkOutput("rspNoReq", 32'(o_dmem_req), 0);
    i_rst_n = 1'b0;
    #1;
    expQ.delete();
    reqQ.delete();
    checkOutput("midRstStall", 32'(o_stall), 0);
    checkOutput("midRstValid", 32'(o_valid), 0);
    checkOutput("midRstAlu", o_alu_result, 0);
    checkOutput("midRstInst", o_inst, 0);
    checkOutput("midRstLoad", o_load_data, 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    i_dmem_rvalid = 1'b1;
    i_dmem_rdata = 32'hDEADBEEF;
    @(posedge i_clk); #1;
    i_dmem_rvalid = 1'b0;
    repeat (3) begin
      checkOutput("postRstValid", 32'(o_valid), 0);
      checkOutput("postRstStall", 32'(o_stall), 0);
      @(posedge i_clk); #1;
    end
    checkOutput("postRstLoad", o_load_data, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports i_clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have execute-side inputs, from execute stage:
- i_valid 1
- i_inst 32
- i_alu_result 32 (address or ALU value)
- i_data_2 32 (store data)
- i_mem_rw 1 (1=store)
- i_load_store_mode 3
- i_wb_sel 2
- i_pc_inc 32
- i_reg_wr_en 1
REQ-004 SHALL have port o_stall, output, 1, upstream hold request.
REQ-005 SHALL have data-memory outputs:
- o_dmem_req 1
- o_dmem_we 1
- o_dmem_addr 32, word-aligned, [1:0]=0
- o_dmem_wdata 32
- o_dmem_be 4
REQ-006 SHALL have data-memory inputs:
- i_dmem_gnt 1, request accepted
- i_dmem_rvalid 1
- i_dmem_rdata 32
REQ-007 SHALL have writeback outputs:
- o_valid 1
- o_inst 32
- o_alu_result 32
- o_load_data 32
- o_pc_inc 32
- o_wb_sel 2
- o_reg_wr_en 1
- o_misaligned 1

Function
REQ-008 SHALL classify captured op: store if i_mem_rw=1; load if i_mem_rw=0 and i_wb_sel=2'b00; otherwise non-memory.
REQ-009 SHALL decode i_load_store_mode as 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes treated as W.
REQ-010 SHALL flag misaligned when H/HU and addr[0]=1, or W and addr[1:0]!=0.
REQ-011 SHALL implement FSM IDLE, REQ, RSP; o_stall=1 in every state except IDLE.
REQ-012 SHALL, in IDLE with i_valid=1, capture all execute-side inputs into internal registers.
REQ-013 SHALL, on IDLE capture:
- non-memory or misaligned: stay IDLE, issue no dmem request.
- otherwise: go to REQ.
REQ-014 SHALL, in REQ:
- drive o_dmem_req=1 with address, we, wdata, be held stable until i_dmem_gnt=1.
- on gnt, go to IDLE for stores, RSP for loads.
REQ-015 SHALL, in RSP, hold o_dmem_req=0 and wait for i_dmem_rvalid=1, then go to IDLE; i_dmem_rvalid outside RSP SHALL be ignored.
REQ-016 SHALL generate store lanes:
- B: be=0001<<addr[1:0], wdata=byte replicated x4.
- H: be=0011<<addr[1:0], wdata=halfword replicated x2.
- W: be=1111, wdata=i_data_2.
REQ-017 SHALL, on rvalid, select the byte/halfword by addr[1:0]; sign-extend for B/H, zero-extend for BU/HU; register the result to o_load_data.
REQ-018 SHALL pulse o_valid for exactly one cycle, the cycle after:
- non-memory/misaligned capture, or
- store gnt, or
- load rvalid.
o_inst, o_alu_result, o_pc_inc, o_wb_sel, o_reg_wr_en SHALL equal captured values while o_valid=1.
REQ-019 SHALL, on misaligned, force o_reg_wr_en=0 and o_misaligned=1 on the o_valid cycle; o_misaligned=0 otherwise.
REQ-020 SHALL give latency from capture to o_valid: 1 cycle (non-mem); 2+gnt-wait (store); 3+gnt-wait+rvalid-wait (load).
REQ-021 SHALL accept a new instruction in the same cycle o_valid is high, back-to-back.

Reset
REQ-022 SHALL, while i_rst_n=0, immediately force:
- state IDLE.
- o_valid, o_stall, o_dmem_req, o_dmem_we, o_misaligned, o_reg_wr_en=0.
- o_dmem_be=0.
- all 32-bit outputs=0, o_wb_sel=0.
REQ-023 SHALL, on reset mid-transaction (REQ or RSP), abandon the access; a subsequent i_dmem_rvalid SHALL be ignored.

Verification
REQ-024 Non-mem op: ALU op, result 0x1234 captured at cycle N -> o_valid=1 at N+1, o_alu_result=0x1234, o_stall=0 throughout.
REQ-025 Store byte: SB, addr 0x1003, data 0xAB, gnt delayed 2 cycles -> o_dmem_req held 3 cycles, be=1000, wdata=0xABABABAB, addr=0x1000, o_stall=1 until gnt, o_valid once.
REQ-026 Signed loads: LB addr 0x2001, rdata 0x0000_8000 -> o_load_data=0xFFFFFF80; LHU addr 0x2002, rdata 0xBEEF0000 -> 0x0000BEEF.
REQ-027 Misaligned LW at 0x3002 -> no o_dmem_req, o_valid next cycle, o_misaligned=1, o_reg_wr_en=0.
REQ-028 Reset during RSP, then rvalid -> outputs zero, FSM IDLE, no o_valid pulse.
